// File: rtl/hazard_pkg.sv
// Shared hazard-controller types: cause encoding and the default ecall source register.
package hazard_pkg;

  typedef enum logic [2:0] {
    NONE,
    LOAD_USE,
    RAW_SB,
    WAW_SB,
    ECALL,
    STRUCT,
    FREEZE,
    REDIRECT
  } hazard_cause_e;

  localparam int ECALL_REG_DEFAULT = 17;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination scoreboard for long-latency EX ops; x0 is never tracked.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_AW   = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lu_issue,
  input  logic [REG_AW-1:0]        lu_issue_rd,
  input  logic                     lu_done,
  input  logic [REG_AW-1:0]        lu_done_rd,
  output logic [(2**REG_AW)-1:0]   pending,
  output logic                     sb_full
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int CW       = $clog2(SB_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                issue_v;
  logic                done_v;

  assign sb_full = (count == FULL_CNT);

  always_comb begin
    issue_v     = lu_issue && (lu_issue_rd != '0);
    done_v      = lu_done && pending[lu_done_rd];
    pending_nxt = pending;
    // Clear before set so a same-register issue+done leaves the bit set.
    if (done_v)  pending_nxt[lu_done_rd]  = 1'b0;
    if (issue_v) pending_nxt[lu_issue_rd] = 1'b1;
    count_nxt = count;
    if (issue_v && !done_v && !sb_full) count_nxt = count + 1'b1;
    else if (done_v && !issue_v)        count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(lu_issue && sb_full));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller: load-use, scoreboard RAW/WAW, ecall, structural stalls, redirect flush, dmem freeze.
// Optional perf counters (stall_cycles, flush_events, freeze_cycles) under HAZARD_PERF_EN.
module hazard_scoreboard_unit import hazard_pkg::*; #(
  parameter int REG_AW       = 5,
  parameter int SB_DEPTH     = 4,
  parameter int ECALL_REG    = ECALL_REG_DEFAULT,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [REG_AW-1:0]       id_rs1,
  input  logic [REG_AW-1:0]       id_rs2,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  input  logic                    id_reg_write,
  input  logic                    id_is_ecall,
  input  logic                    id_is_long,
  input  logic                    ex_mem_read,
  input  logic                    ex_reg_write,
  input  logic [REG_AW-1:0]       ex_rd,
  input  logic                    ex_is_jal,
  input  logic                    ex_is_jalr,
  input  logic                    ex_is_branch,
  input  logic                    ex_bcond,
  input  logic                    lu_issue,
  input  logic [REG_AW-1:0]       lu_issue_rd,
  input  logic                    lu_done,
  input  logic [REG_AW-1:0]       lu_done_rd,
  input  logic                    dmem_busy,
  output logic                    pc_write,
  output logic                    if_id_write,
  output logic                    id_ex_write,
  output logic                    ex_mem_write,
  output logic                    control_op,
  output logic [FLUSH_STAGES-1:0] flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_events,
  output logic [31:0]             freeze_cycles,
`endif
  output logic                    sb_full
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam logic [REG_AW-1:0] ECALL_RD = REG_AW'(ECALL_REG);

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [NUM_REGS-1:0] pending;
  logic                load_use, raw_hit, waw_hit, ecall_hit, struct_hit, redirect;
  hazard_cause_e       cause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  hazard_scoreboard #(.REG_AW(REG_AW), .SB_DEPTH(SB_DEPTH)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .lu_done     (lu_done),
    .lu_done_rd  (lu_done_rd),
    .pending     (pending),
    .sb_full     (sb_full)
  );

  always_comb begin
    load_use   = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // A result retiring this cycle still counts as pending.
    raw_hit    = (id_use_rs1 && id_rs1 != '0 && pending[id_rs1]) ||
                 (id_use_rs2 && id_rs2 != '0 && pending[id_rs2]);
    waw_hit    = id_reg_write && pending[id_rd];
    ecall_hit  = id_is_ecall && (pending[ECALL_REG] || (ex_reg_write && ex_rd == ECALL_RD));
    struct_hit = id_is_long && sb_full;
    redirect   = ex_is_jal || ex_is_jalr || (ex_is_branch && ex_bcond);
    cause = NONE;
    if (dmem_busy)       cause = FREEZE;
    else if (redirect)   cause = REDIRECT;
    else if (load_use)   cause = LOAD_USE;
    else if (raw_hit)    cause = RAW_SB;
    else if (waw_hit)    cause = WAW_SB;
    else if (ecall_hit)  cause = ECALL;
    else if (struct_hit) cause = STRUCT;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    control_op   = 1'b0;
    flush        = '0;
    case (cause)
      FREEZE: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end
      REDIRECT: flush = '1;
      LOAD_USE, RAW_SB, WAW_SB, ECALL, STRUCT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        control_op  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      flush_events  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (cause inside {LOAD_USE, RAW_SB, WAW_SB, ECALL, STRUCT}) stall_cycles <= stall_cycles + 32'd1;
      if (cause == REDIRECT) flush_events  <= flush_events + 32'd1;
      if (cause == FREEZE)   freeze_cycles <= freeze_cycles + 32'd1;
    end
  end
`endif

endmodule
